symbol_fifo: RTL and testbench

Parametrised single-clock circular FIFO for decoded symbol words, the successor to the fixed 10 x 20-bit symbol buffer. It sits between the symbol decoder and the display/UART consumer. It adds configurable width, depth and write mode, a synchronous pop handshake, occupancy reporting and a sticky overflow flag. DEPTH need not be a power of two; pointers wrap explicitly.

---
 rtl/symbol_fifo.sv | 111 +++++++++++
 tb/tb_symbol_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/symbol_fifo.sv
// Parametrised single-clock circular FIFO for decoded symbol words with show-ahead read,
// occupancy and sticky overflow. Define SYMBOL_FIFO_DROP_OLDEST_EN to overwrite the oldest entry when full.
module symbol_fifo #(
    parameter int WIDTH      = 20,
    parameter int DEPTH      = 10,
    parameter int CHANGE_DET = 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_w_valid,
    input  logic [WIDTH-1:0] i_w_data,
    input  logic             i_r_next,
    input  logic             i_ovf_clr,
    output logic [WIDTH-1:0] o_r_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [CW-1:0]    o_count,
    output logic             o_ovf
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    r_ptr_reg, r_ptr_next;
    logic [PW-1:0]    w_ptr_reg, w_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] last_reg;
    logic             ovf_reg;

    logic             full, wreq, rreq, mem_we, r_adv, ovf_set;
    logic [DEPTH-1:0] entry_we;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        full    = (count_reg == CW'(DEPTH));
        wreq    = i_w_valid && ((CHANGE_DET == 0) || (i_w_data != last_reg));
        rreq    = i_r_next && (count_reg != '0);
        ovf_set = wreq && full && !rreq;
`ifdef SYMBOL_FIFO_DROP_OLDEST_EN
        // Overwrite the oldest entry: write proceeds and the head is pushed forward.
        mem_we  = wreq;
        r_adv   = rreq || ovf_set;
`else
        mem_we  = wreq && (!full || rreq);
        r_adv   = rreq;
`endif
        w_ptr_next = mem_we ? wrap_inc(w_ptr_reg) : w_ptr_reg;
        r_ptr_next = r_adv  ? wrap_inc(r_ptr_reg) : r_ptr_reg;
        count_next = count_reg;
        if (mem_we && !r_adv) begin
            count_next = count_reg + CW'(1);
        end else if (!mem_we && r_adv) begin
            count_next = count_reg - CW'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign entry_we[gi] = mem_we && (w_ptr_reg == PW'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_we[i]) begin
                    mem_reg[i] <= i_w_data;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr_reg <= '0;
            w_ptr_reg <= '0;
            count_reg <= '0;
            last_reg  <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            r_ptr_reg <= r_ptr_next;
            w_ptr_reg <= w_ptr_next;
            count_reg <= count_next;
            // Remember every requested word, accepted or dropped, so a held value never re-requests.
            if (wreq) begin
                last_reg <= i_w_data;
            end
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end else if (i_ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign o_r_data = mem_reg[r_ptr_reg];
    assign o_empty  = (count_reg == '0);
    assign o_full   = full;
    assign o_count  = count_reg;
    assign o_ovf    = ovf_reg;

endmodule

// File: tb/tb_symbol_fifo.sv
// Directed self-checking bench for symbol_fifo: one every-cycle-write instance and one change-detect instance.
module tb_symbol_fifo;
    localparam int WIDTH = 20;
    localparam int DEPTH = 10;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;

    logic             w_valid = 1'b0;
    logic [WIDTH-1:0] w_data  = '0;
    logic             r_next  = 1'b0;
    logic             ovf_clr = 1'b0;
    logic [WIDTH-1:0] r_data;
    logic             empty, full, ovf;
    logic [CW-1:0]    count;

    logic             c_w_valid = 1'b0;
    logic [WIDTH-1:0] c_w_data  = '0;
    logic             c_r_next  = 1'b0;
    logic             c_ovf_clr = 1'b0;
    logic [WIDTH-1:0] c_r_data;
    logic             c_empty, c_full, c_ovf;
    logic [CW-1:0]    c_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    symbol_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANGE_DET(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_w_valid(w_valid), .i_w_data(w_data),
        .i_r_next(r_next), .i_ovf_clr(ovf_clr), .o_r_data(r_data),
        .o_empty(empty), .o_full(full), .o_count(count), .o_ovf(ovf)
    );

    symbol_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANGE_DET(1)) dut_cd (
        .i_clk(clk), .i_rst(rst), .i_w_valid(c_w_valid), .i_w_data(c_w_data),
        .i_r_next(c_r_next), .i_ovf_clr(c_ovf_clr), .o_r_data(c_r_data),
        .o_empty(c_empty), .o_full(c_full), .o_count(c_count), .o_ovf(c_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-12s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"},  32'(full),  32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_rdata"}, 32'(r_data), 32'd0);
        chk({tag, "_ovf"},   32'(ovf),   32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_head;

        // Reset state
        step();
        step();
        chk_reset_outputs("rst");
        chk("rst_cd_empty", 32'(c_empty), 32'd1);
        rst = 1'b0;

        // Change detect: held 0x5 produces exactly one entry
        c_w_valid = 1'b1;
        c_w_data  = 20'h00005;
        for (int i = 0; i < 5; i++) step();
        chk("cd_count", 32'(c_count), 32'd1);
        chk("cd_rdata", 32'(c_r_data), 32'h5);
        c_w_valid = 1'b0;

        // Change detect: first word of 0 is suppressed after reset
        do_reset();
        c_w_valid = 1'b1;
        c_w_data  = '0;
        for (int i = 0; i < 3; i++) step();
        chk("cd0_empty", 32'(c_empty), 32'd1);
        chk("cd0_count", 32'(c_count), 32'd0);
        c_w_valid = 1'b0;

        // Fill 0x1..0xA
        for (int i = 1; i <= DEPTH; i++) begin
            w_valid = 1'b1;
            w_data  = WIDTH'(i);
            step();
            chk("fill_count", 32'(count), 32'(i));
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_head", 32'(r_data), 32'h1);
        chk("fill_ovf",  32'(ovf), 32'd0);

        // Overflowing write with simultaneous clear: set wins
        w_data  = 20'h0000B;
        ovf_clr = 1'b1;
        step();
        w_valid = 1'b0;
        ovf_clr = 1'b0;
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_count", 32'(count), 32'd10);
`ifdef SYMBOL_FIFO_DROP_OLDEST_EN
        exp_head = 32'h2;
`else
        exp_head = 32'h1;
`endif
        chk("ovf_head", 32'(r_data), exp_head);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'd0);

        // Drain in order
        r_next = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            chk("drain_data", 32'(r_data), exp_head + 32'(k));
            chk("drain_count", 32'(count), 32'(DEPTH - k));
            step();
        end
        r_next = 1'b0;
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_count0", 32'(count), 32'd0);

        // Push and pop while empty: write accepted, pop ignored
        w_valid = 1'b1;
        w_data  = 20'h00055;
        r_next  = 1'b1;
        step();
        w_valid = 1'b0;
        r_next  = 1'b0;
        chk("pe_count", 32'(count), 32'd1);
        chk("pe_rdata", 32'(r_data), 32'h55);
        r_next = 1'b1;
        step();
        r_next = 1'b0;
        chk("pe_empty", 32'(empty), 32'd1);

        // Push and pop while full: both proceed, no overflow
        w_valid = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            w_data = WIDTH'(i);
            step();
        end
        w_data = 20'h0000C;
        r_next = 1'b1;
        step();
        w_valid = 1'b0;
        r_next  = 1'b0;
        chk("pf_count", 32'(count), 32'd10);
        chk("pf_ovf",   32'(ovf), 32'd0);
        chk("pf_head",  32'(r_data), 32'h2);
        r_next = 1'b1;
        for (int k = 2; k <= DEPTH; k++) begin
            chk("pf_drain", 32'(r_data), 32'(k));
            step();
        end
        chk("pf_last", 32'(r_data), 32'hC);
        step();
        r_next = 1'b0;
        chk("pf_empty", 32'(empty), 32'd1);

        // Wrap-around from a clean reset: 7 in, 7 out, 7 in, 7 out
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            w_valid = 1'b1;
            for (int i = 0; i < 7; i++) begin
                w_data = WIDTH'(32'h21 + 32'(pass * 16) + 32'(i));
                step();
                chk("wrap_wcount", 32'(count), 32'(i + 1));
            end
            w_valid = 1'b0;
            r_next  = 1'b1;
            for (int i = 0; i < 7; i++) begin
                chk("wrap_rdata", 32'(r_data), 32'h21 + 32'(pass * 16) + 32'(i));
                step();
                chk("wrap_rcount", 32'(count), 32'(6 - i));
            end
            r_next = 1'b0;
        end

        // Asynchronous reset mid-transfer, sampled before any clock edge
        w_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w_data = WIDTH'(32'h70 + 32'(i));
            step();
        end
        w_valid = 1'b0;
        r_next  = 1'b1;
        step();
        chk("mid_count", 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("arst");
        r_next = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
